ex_muldiv_seq: RTL and testbench

Sequencer for RV32M multiply/divide instructions held in the execute stage. It captures operands when an M-extension instruction reaches EX. It then runs an iterative shift-add multiplier or restoring divider over several cycles, holds the pipeline with stall_o, and returns a registered result for one cycle. It sits beside the EX ALU and its result is muxed onto the EX/MEM result path.

---
 rtl/ex_muldiv_seq_if.sv | 21 ++
 rtl/ex_muldiv_seq.sv | 173 +++++++++++++++++
 tb/tb_ex_muldiv_seq.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_seq_if.sv
// rtl/ex_muldiv_seq_if.sv - EX-stage request/response bundle between the pipeline and the M-extension sequencer
interface ex_muldiv_seq_if;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] oper1_i;
    logic [31:0] oper2_i;
    logic        flush_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;

    modport master (
        output start_i, op_i, oper1_i, oper2_i, flush_i,
        input  stall_o, done_o, result_o
    );

    modport slave (
        input  start_i, op_i, oper1_i, oper2_i, flush_i,
        output stall_o, done_o, result_o
    );
endinterface

// File: rtl/ex_muldiv_seq.sv
// rtl/ex_muldiv_seq.sv - iterative RV32M multiply/divide sequencer for the execute stage
module ex_muldiv_seq #(
    parameter int UNROLL = 1
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    ex_muldiv_seq_if.slave       bus
);
    localparam int N  = 32 / UNROLL;
    localparam int CW = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [1:0]      op_q, op_d;
    logic [63:0]     acc_q, acc_d;
    logic [31:0]     opnd_q, opnd_d;
    logic            neg_q, neg_d;
    logic [31:0]     result_q, result_d;

    logic            a_signed, b_signed, a_neg, b_neg;
    logic [31:0]     a_mag, b_mag;
    logic            div_zero, div_ovf;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (bus.op_i)
            3'd0, 3'd1, 3'd4, 3'd6: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'd2:    a_signed = 1'b1;
            default: ;
        endcase
        a_neg    = a_signed & bus.oper1_i[31];
        b_neg    = b_signed & bus.oper2_i[31];
        a_mag    = a_neg ? (32'd0 - bus.oper1_i) : bus.oper1_i;
        b_mag    = b_neg ? (32'd0 - bus.oper2_i) : bus.oper2_i;
        div_zero = (bus.oper2_i == 32'd0);
        div_ovf  = ~bus.op_i[0] & (bus.oper1_i == 32'h8000_0000) & (bus.oper2_i == 32'hFFFF_FFFF);
    end

    // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    logic [63:0] acc_step;
    logic [32:0] sum;
    logic [32:0] trial;

    always_comb begin
        acc_step = acc_q;
        sum      = '0;
        trial    = '0;
        for (int k = 0; k < UNROLL; k++) begin
            if (state_q == S_MUL) begin
                sum      = {1'b0, acc_step[63:32]} + (acc_step[0] ? {1'b0, opnd_q} : 33'd0);
                acc_step = {sum, acc_step[31:1]};
            end else begin
                // trial[32] set means the shifted remainder is below the divisor: restore
                trial = {acc_step[63:32], acc_step[31]} - {1'b0, opnd_q};
                if (trial[32]) begin
                    acc_step = {acc_step[62:0], 1'b0};
                end else begin
                    acc_step = {trial[31:0], acc_step[30:0], 1'b1};
                end
            end
        end
    end

    logic [63:0] prod_fix;
    logic [31:0] div_val;
    logic [31:0] final_res;

    always_comb begin
        prod_fix = neg_q ? (64'd0 - acc_step) : acc_step;
        div_val  = op_q[1] ? acc_step[63:32] : acc_step[31:0];
        if (state_q == S_MUL) begin
            final_res = (op_q == 2'd0) ? prod_fix[31:0] : prod_fix[63:32];
        end else begin
            final_res = neg_q ? (32'd0 - div_val) : div_val;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    op_d    = bus.op_i[1:0];
                    count_d = '0;
                    if (bus.op_i[2]) begin
                        neg_d = bus.op_i[1] ? a_neg : (a_neg ^ b_neg);
                        if (div_zero) begin
                            result_d = bus.op_i[1] ? bus.oper1_i : 32'hFFFF_FFFF;
                            state_d  = S_DONE;
                        end else if (div_ovf) begin
                            result_d = bus.op_i[1] ? 32'd0 : 32'h8000_0000;
                            state_d  = S_DONE;
                        end else begin
                            acc_d   = {32'd0, a_mag};
                            opnd_d  = b_mag;
                            state_d = S_DIV;
                        end
                    end else begin
                        neg_d   = a_neg ^ b_neg;
                        acc_d   = {32'd0, b_mag};
                        opnd_d  = a_mag;
                        state_d = S_MUL;
                    end
                end
            end
            S_MUL, S_DIV: begin
                acc_d   = acc_step;
                count_d = count_q + CW'(1);
                if (count_q == CW'(N - 1)) begin
                    result_d = final_res;
                    count_d  = '0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // flush kills whatever is in flight, including a start arriving in the same cycle
        if (bus.flush_i) begin
            state_d  = S_IDLE;
            count_d  = '0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign bus.stall_o  = rstn_i & (((state_q == S_IDLE) & bus.start_i & ~bus.flush_i) |
                                    (state_q == S_MUL) | (state_q == S_DIV));
    assign bus.done_o   = (state_q == S_DONE);
    assign bus.result_o = result_q;
endmodule

// File: tb/tb_ex_muldiv_seq.sv
// tb/tb_ex_muldiv_seq.sv - scoreboard bench for ex_muldiv_seq with UNROLL=1 and UNROLL=4 instances
module tb_ex_muldiv_seq;
    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    logic        start_v  [2];
    logic [2:0]  op_v     [2];
    logic [31:0] o1_v     [2];
    logic [31:0] o2_v     [2];
    logic        flush_v  [2];
    logic        stall_w  [2];
    logic        done_w   [2];
    logic [31:0] result_w [2];
    logic        prev_done[2];
    int          done_cnt [2];
    exp_t        sb [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ex_muldiv_seq_if bus ();
        assign bus.start_i  = start_v[g];
        assign bus.op_i     = op_v[g];
        assign bus.oper1_i  = o1_v[g];
        assign bus.oper2_i  = o2_v[g];
        assign bus.flush_i  = flush_v[g];
        assign stall_w[g]   = bus.stall_o;
        assign done_w[g]    = bus.done_o;
        assign result_w[g]  = bus.result_o;

        ex_muldiv_seq #(.UNROLL(g == 0 ? 1 : 4)) u_dut (
            .clk_i  (clk),
            .rstn_i (rstn),
            .bus    (bus)
        );

        always @(negedge clk) begin : mon
            exp_t e;
            if (rstn) begin
                if (done_w[g]) begin
                    check($sformatf("done_width[%0d]", g), 64'(prev_done[g]), 64'd0);
                    if (sb[g].size() == 0) begin
                        check($sformatf("unexpected_done[%0d]", g), 64'd1, 64'd0);
                    end else begin
                        e = sb[g].pop_front();
                        check($sformatf("result[%0d]", g), 64'(result_w[g]), 64'(e.res));
                        check($sformatf("done_cycle[%0d]", g), 64'(cyc), 64'(e.cyc));
                    end
                    done_cnt[g]++;
                end
                prev_done[g] = done_w[g];
            end else begin
                prev_done[g] = 1'b0;
            end
        end
    end

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb_, ua, ub;
        logic [63:0] t;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        case (op)
            3'd0: begin t = sa * sb_; return t[31:0]; end
            3'd1: begin t = sa * sb_; return t[63:32]; end
            3'd2: begin t = sa * ub;  return t[63:32]; end
            3'd3: begin t = ua * ub;  return t[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                t = sa / sb_; return t[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                t = sa % sb_; return t[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return (op >= 3'd4) && ((b == 0) ||
               ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // called just after a rising edge; returns just after the rising edge that ends DONE
    task automatic issue(input int d, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit hold);
        exp_t e;
        int   n;
        int   nc;
        bit   sp;
        nc = (d == 0) ? 32 : 8;
        sp = is_special(op, a, b);
        start_v[d] = 1'b1;
        op_v[d]    = op;
        o1_v[d]    = a;
        o2_v[d]    = b;
        e.res = model(op, a, b);
        e.cyc = cyc + (sp ? 1 : nc + 1);
        sb[d].push_back(e);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!stall_w[d]) break;
            n++;
            if (n >= 2) begin
                o1_v[d] = $urandom;
                o2_v[d] = $urandom;
            end
        end
        check($sformatf("stall_len[%0d] op%0d", d, op), 64'(n), 64'(sp ? 1 : nc + 1));
        @(posedge clk); #1;
        if (!hold) start_v[d] = 1'b0;
    endtask

    initial begin
        int snap;
        for (int d = 0; d < 2; d++) begin
            start_v[d] = 1'b0; op_v[d] = '0; o1_v[d] = '0; o2_v[d] = '0;
            flush_v[d] = 1'b0; prev_done[d] = 1'b0; done_cnt[d] = 0;
        end

        // reset state, including stall suppression with start asserted
        #2;
        start_v[0] = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_stall[%0d]", d), 64'(stall_w[d]), 64'd0);
            check($sformatf("rst_done[%0d]", d), 64'(done_w[d]), 64'd0);
            check($sformatf("rst_result[%0d]", d), 64'(result_w[d]), 64'd0);
        end
        start_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;

        // directed cases on UNROLL=1
        issue(0, 3'd0, 32'd7,          32'hFFFF_FFFD, 0);
        issue(0, 3'd1, 32'h8000_0000,  32'h8000_0000, 0);
        issue(0, 3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0);
        issue(0, 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0);
        issue(0, 3'd4, 32'hFFFF_FFF9,  32'd2,         0);
        issue(0, 3'd6, 32'hFFFF_FFF9,  32'd2,         0);
        issue(0, 3'd5, 32'd100,        32'd7,         0);
        issue(0, 3'd7, 32'd100,        32'd7,         0);
        issue(0, 3'd5, 32'd5,          32'd0,         0);
        issue(0, 3'd7, 32'd5,          32'd0,         0);
        issue(0, 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 0);
        issue(0, 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 0);

        // flush at count 10 of a DIV, start held through the flush cycle
        snap = done_cnt[0];
        start_v[0] = 1'b1; op_v[0] = 3'd4; o1_v[0] = 32'd1000; o2_v[0] = 32'd3;
        repeat (11) @(posedge clk);
        #1 flush_v[0] = 1'b1;
        @(posedge clk); #1;
        flush_v[0] = 1'b0; start_v[0] = 1'b0;
        @(negedge clk);
        check("flush_stall_low", 64'(stall_w[0]), 64'd0);
        @(posedge clk); #1;
        issue(0, 3'd0, 32'd6, 32'd7, 0);
        check("flush_no_done", 64'(done_cnt[0]), 64'(snap + 1));

        // start coinciding with flush in IDLE is dropped
        snap = done_cnt[0];
        start_v[0] = 1'b1; flush_v[0] = 1'b1; op_v[0] = 3'd0;
        @(negedge clk);
        check("idle_flush_stall", 64'(stall_w[0]), 64'd0);
        @(posedge clk); #1;
        start_v[0] = 1'b0; flush_v[0] = 1'b0;
        repeat (4) @(posedge clk); #1;
        check("idle_flush_no_done", 64'(done_cnt[0]), 64'(snap));

        // UNROLL=4 back-to-back with start held through the stall
        issue(1, 3'd0, 32'd12345,  32'hFFFF_FF00, 1);
        issue(1, 3'd5, 32'd100000, 32'd77,        0);

        // reset asserted mid-MUL
        start_v[1] = 1'b1; op_v[1] = 3'd1; o1_v[1] = $urandom; o2_v[1] = $urandom;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_rst_stall", 64'(stall_w[1]), 64'd1);
        #1 rstn = 1'b0;
        #1;
        check("mid_rst_stall", 64'(stall_w[1]), 64'd0);
        check("mid_rst_done", 64'(done_w[1]), 64'd0);
        @(posedge clk); #1;
        start_v[1] = 1'b0;
        rstn = 1'b1;
        @(posedge clk); #1;

        // randomized traffic on both instances
        for (int i = 0; i < 60; i++) begin
            int d;
            d = i % 2;
            issue(d, 3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(), bit'($urandom_range(0, 1)));
            start_v[d] = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (5) @(posedge clk);
        #1;
        check("sb_empty[0]", 64'(sb[0].size()), 64'd0);
        check("sb_empty[1]", 64'(sb[1].size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
